// File: rtl/explosion_renderer.sv
// Explosion overlay: latches a trigger position, plays a multi-frame 32x32 sprite
// paced by vsync ticks, and turns DrawX/DrawY into sprite ROM addresses and palette indices.
module explosion_renderer #(
   parameter int TICKS_PER_FRAME = 4,
   parameter int NUM_FRAMES      = 5
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        trigger,
   input  logic [9:0]  trig_x,
   input  logic [9:0]  trig_y,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [4:0]  rom_data,
   output logic [12:0] rom_addr,
   output logic        pixel_valid,
   output logic [2:0]  pixel_index,
   output logic        busy,
   output logic        done,
   output logic        state_dbg
);

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   localparam logic [3:0] LAST_TICK  = 4'(TICKS_PER_FRAME - 1);
   localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);

   state_t      state, state_n;
   logic [9:0]  x0, x0_n, y0, y0_n;
   logic [2:0]  frame, frame_n;
   logic [3:0]  tick_cnt, tick_cnt_n;
   logic        done_n;
   logic        in_region, in_region_q;
   logic [10:0] x_end, y_end;
   logic [4:0]  dx, dy;
   logic        unused_rom_bits;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         x0          <= '0;
         y0          <= '0;
         frame       <= '0;
         tick_cnt    <= '0;
         done        <= 1'b0;
         in_region_q <= 1'b0;
      end else begin
         state       <= state_n;
         x0          <= x0_n;
         y0          <= y0_n;
         frame       <= frame_n;
         tick_cnt    <= tick_cnt_n;
         done        <= done_n;
         in_region_q <= in_region;
      end
   end

   // A trigger always restarts the animation; a tick in the same cycle is dropped.
   always_comb begin
      state_n    = state;
      x0_n       = x0;
      y0_n       = y0;
      frame_n    = frame;
      tick_cnt_n = tick_cnt;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               x0_n       = trig_x;
               y0_n       = trig_y;
               frame_n    = '0;
               tick_cnt_n = '0;
               state_n    = PLAY;
            end
         end
         PLAY: begin
            if (trigger) begin
               x0_n       = trig_x;
               y0_n       = trig_y;
               frame_n    = '0;
               tick_cnt_n = '0;
            end else if (frame_tick) begin
               if (tick_cnt == LAST_TICK) begin
                  tick_cnt_n = '0;
                  if (frame == LAST_FRAME) begin
                     frame_n = '0;
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     frame_n = frame + 3'd1;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy      = (state == PLAY);
   assign state_dbg = state;

   // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
   assign x_end = {1'b0, x0} + 11'd32;
   assign y_end = {1'b0, y0} + 11'd32;
   assign in_region = busy
                    && ({1'b0, DrawX} >= {1'b0, x0}) && ({1'b0, DrawX} < x_end)
                    && ({1'b0, DrawY} >= {1'b0, y0}) && ({1'b0, DrawY} < y_end);

   // Only the low five bits of the offsets matter inside a 32x32 tile.
   assign dx = DrawX[4:0] - x0[4:0];
   assign dy = DrawY[4:0] - y0[4:0];
   assign rom_addr = in_region ? {frame, dy, dx} : 13'd0;

   assign pixel_valid     = in_region_q && (rom_data[2:0] != 3'd0);
   assign pixel_index     = pixel_valid ? rom_data[2:0] : 3'd0;
   assign unused_rom_bits = ^rom_data[4:3];

endmodule

// File: tb/tb_explosion_renderer.sv
// Directed bench for explosion_renderer: a reference model predicts rom_addr, busy/done,
// and a scoreboard queue holds each pixel's expected {valid,index} until it emerges.
module tb_explosion_renderer;

   localparam int TPF = 4;
   localparam int NF  = 5;

   logic        Clk = 1'b0;
   logic        Reset, frame_tick, trigger;
   logic [9:0]  trig_x, trig_y, DrawX, DrawY;
   logic [4:0]  rom_data;
   logic [12:0] rom_addr;
   logic        pixel_valid, busy, done, state_dbg;
   logic [2:0]  pixel_index;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   logic [3:0]  exp_q[$];
   logic [4:0]  pend_rv = 5'd0;
   logic [12:0] obs_addr;
   logic [3:0]  obs_pix;

   // reference model state
   int m_x0 = 0, m_y0 = 0, m_frame = 0, m_tick = 0;
   bit m_busy = 0, m_done = 0;

   explosion_renderer #(.TICKS_PER_FRAME(TPF), .NUM_FRAMES(NF)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .trigger(trigger),
      .trig_x(trig_x), .trig_y(trig_y), .DrawX(DrawX), .DrawY(DrawY),
      .rom_data(rom_data), .rom_addr(rom_addr), .pixel_valid(pixel_valid),
      .pixel_index(pixel_index), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance the model.
   task automatic cyc(input int x, input int y, input logic [4:0] rv, input bit tk,
                      input bit tg, input int tx, input int ty, input bit rs);
      bit inreg;
      int addr;
      logic [3:0] e;
      Reset = rs; frame_tick = tk; trigger = tg;
      trig_x = 10'(tx); trig_y = 10'(ty);
      DrawX = 10'(x); DrawY = 10'(y);
      rom_data = pend_rv;
      @(negedge Clk);
      inreg = m_busy && x >= m_x0 && x < m_x0 + 32 && y >= m_y0 && y < m_y0 + 32;
      addr  = inreg ? m_frame * 1024 + (y - m_y0) * 32 + (x - m_x0) : 0;
      obs_addr = rom_addr;
      obs_pix  = {pixel_valid, pixel_index};
      check("rom_addr", 32'(rom_addr), 32'(addr));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("state_dbg", 32'(state_dbg), 32'(m_busy));
      if (done === 1'b1) done_seen++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pixel", 32'(obs_pix), 32'(e));
      end
      if (!rs && inreg && rv[2:0] != 3'd0) exp_q.push_back({1'b1, rv[2:0]});
      else exp_q.push_back(4'd0);
      pend_rv = rv;
      m_done = 0;
      if (rs) begin
         m_busy = 0; m_frame = 0; m_tick = 0; m_x0 = 0; m_y0 = 0;
      end else if (tg) begin
         m_busy = 1; m_x0 = tx; m_y0 = ty; m_frame = 0; m_tick = 0;
      end else if (m_busy && tk) begin
         if (m_tick == TPF - 1) begin
            m_tick = 0;
            if (m_frame == NF - 1) begin
               m_busy = 0; m_frame = 0; m_done = 1;
            end else m_frame++;
         end else m_tick++;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic pix(input int x, input int y, input logic [4:0] rv);
      cyc(x, y, rv, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // A random-length gap of random pixels, then one frame_tick cycle.
   task automatic tick_rand();
      int gap;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++)
         pix(m_x0 + $urandom_range(0, 40) - 4, m_y0 + $urandom_range(0, 40) - 4, 5'($urandom_range(0, 31)));
      cyc(m_x0 + $urandom_range(0, 31), m_y0 + $urandom_range(0, 31), 5'($urandom_range(0, 31)),
          1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; trigger = 1'b1;
      trig_x = '0; trig_y = '0; DrawX = '0; DrawY = '0; rom_data = '0;
      repeat (2) @(posedge Clk);
      #1;

      // reset held with trigger asserted
      for (int i = 0; i < 3; i++) cyc(10, 10, 5'd7, 1'b1, 1'b1, 5, 5, 1'b1);
      pix(0, 0, 5'd0);

      // basic draw, out-of-region, transparency, ignored upper ROM bits
      cyc(0, 0, 5'd0, 1'b0, 1'b1, 100, 50, 1'b0);
      pix(105, 52, 5'd3);
      check("addr_69", 32'(obs_addr), 32'd69);
      pix(132, 52, 5'd7);
      check("addr_outside", 32'(obs_addr), 32'd0);
      check("pix_idx3", 32'(obs_pix), 32'h0B);
      pix(110, 60, 5'd0);
      check("pix_outside", 32'(obs_pix), 32'h0);
      pix(111, 60, 5'b11010);
      check("pix_transparent", 32'(obs_pix), 32'h0);
      pix(0, 0, 5'd0);
      check("pix_idx2", 32'(obs_pix), 32'h0A);

      // full playback: 16 ticks to frame 4, corner address, 4 more ticks to done
      for (int i = 0; i < 16; i++) tick_rand();
      pix(131, 81, 5'd4);
      check("addr_5119", 32'(obs_addr), 32'd5119);
      for (int i = 0; i < 4; i++) tick_rand();
      pix(0, 0, 5'd0);
      pix(0, 0, 5'd0);
      check("done_once", 32'(done_seen), 32'd1);
      check("idle_after_play", 32'(busy), 32'd0);

      // right-edge clip
      cyc(0, 0, 5'd0, 1'b0, 1'b1, 620, 100, 1'b0);
      pix(5, 100, 5'd6);
      check("clip_no_wrap", 32'(obs_addr), 32'd0);
      pix(639, 100, 5'd1);
      check("clip_col19", 32'(obs_addr), 32'd19);
      check("clip_pix_off", 32'(obs_pix), 32'h0);
      pix(0, 0, 5'd0);
      check("clip_pix_on", 32'(obs_pix), 32'h09);

      // retrigger at frame 2 coinciding with a tick
      for (int i = 0; i < 8; i++) tick_rand();
      cyc(0, 0, 5'd0, 1'b1, 1'b1, 200, 200, 1'b0);
      pix(201, 202, 5'd2);
      check("retrig_addr", 32'(obs_addr), 32'd65);
      for (int i = 0; i < 3; i++) tick_rand();
      pix(201, 202, 5'd2);
      check("retrig_tick_dropped", 32'(obs_addr), 32'd65);
      check("retrig_no_done", 32'(done_seen), 32'd1);

      // reset mid-animation at frame 3
      for (int i = 0; i < 9; i++) tick_rand();
      cyc(200, 200, 5'd1, 1'b0, 1'b0, 0, 0, 1'b1);
      pix(200, 200, 5'd1);
      check("reset_busy", 32'(busy), 32'd0);
      pix(0, 0, 5'd0);
      pix(0, 0, 5'd0);
      check("reset_no_done", 32'(done_seen), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
